// File: rtl/fp_int_mac_seq.sv
// fp_int_mac_seq: walks one fp_int_mac unit through a dot product of
// FP16 activations and INT4 weights. Each completed MAC result is fed
// back as the accumulator (and aligned exponent) for the next element.
// The final accumulator is returned over a valid/ready result port, and
// a MAC that never signals done is abandoned after MAC_TIMEOUT+1 WAIT cycles.
module fp_int_mac_seq #(
    parameter int ACT_WIDTH   = 16,
    parameter int W_WIDTH     = 4,
    parameter int ACC_WIDTH   = 32,
    parameter int LEN_WIDTH   = 8,
    parameter int MAC_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LEN_WIDTH-1:0] cmd_len,
    input  logic [4:0]           cmd_exp_min,
    input  logic [ACC_WIDTH-1:0] cmd_acc_init,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [ACT_WIDTH-1:0] in_act,
    input  logic [W_WIDTH-1:0]   in_weight,
    output logic                 mac_start,
    output logic [ACT_WIDTH-1:0] mac_activation,
    output logic [W_WIDTH-1:0]   mac_weight,
    output logic [4:0]           mac_exp_min,
    output logic [ACC_WIDTH-1:0] mac_acc,
    input  logic [4:0]           mac_exp_out,
    input  logic [ACC_WIDTH-1:0] mac_out,
    input  logic                 mac_done,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [ACC_WIDTH-1:0] res_acc,
    output logic [4:0]           res_exp,
    output logic [LEN_WIDTH-1:0] res_count,
    output logic                 res_err,
    output logic                 busy
);

    localparam int TMR_WIDTH = $clog2(MAC_TIMEOUT + 1);
    localparam logic [TMR_WIDTH-1:0] TMR_LIMIT = TMR_WIDTH'(MAC_TIMEOUT);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH  = 3'd1;
    localparam logic [2:0] ISSUE  = 3'd2;
    localparam logic [2:0] WAIT   = 3'd3;
    localparam logic [2:0] RESULT = 3'd4;

    logic [2:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [4:0]           exp_q, exp_d;
    logic                 err_q, err_d;
    logic [ACT_WIDTH-1:0] act_q, act_d;
    logic [W_WIDTH-1:0]   weight_q, weight_d;
    logic [TMR_WIDTH-1:0] timer_q, timer_d;
    logic                 cmd_ready_q;

    // Next-state logic: command latch, operand fetch, MAC capture with
    // feedback, and the WAIT watchdog (done wins over timeout in the same cycle).
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        count_d     = count_q;
        acc_d       = acc_q;
        exp_d       = exp_q;
        err_d       = err_q;
        act_d       = act_q;
        weight_d    = weight_q;
        timer_d     = timer_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    remaining_d = cmd_len;
                    exp_d       = cmd_exp_min;
                    acc_d       = cmd_acc_init;
                    count_d     = '0;
                    err_d       = 1'b0;
                    state_d     = (cmd_len == '0) ? RESULT : FETCH;
                end
            end
            FETCH: begin
                if (in_valid) begin
                    act_d    = in_act;
                    weight_d = in_weight;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mac_done) begin
                    acc_d   = mac_out;
                    exp_d   = mac_exp_out;
                    count_d = count_q + 1'b1;
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - 1'b1;
                    end
                    state_d = (remaining_q <= LEN_WIDTH'(1)) ? RESULT : FETCH;
                end else if (timer_q == TMR_LIMIT) begin
                    err_d   = 1'b1;
                    state_d = RESULT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RESULT: begin
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset clears everything so a late MAC done finds IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            count_q     <= '0;
            acc_q       <= '0;
            exp_q       <= '0;
            err_q       <= 1'b0;
            act_q       <= '0;
            weight_q    <= '0;
            timer_q     <= '0;
            cmd_ready_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            count_q     <= count_d;
            acc_q       <= acc_d;
            exp_q       <= exp_d;
            err_q       <= err_d;
            act_q       <= act_d;
            weight_q    <= weight_d;
            timer_q     <= timer_d;
            cmd_ready_q <= (state_d == IDLE);
        end
    end

    assign cmd_ready      = cmd_ready_q;
    assign in_ready       = (state_q == FETCH);
    assign mac_start      = (state_q == ISSUE);
    assign res_valid      = (state_q == RESULT);
    assign busy           = (state_q != IDLE);
    assign mac_activation = act_q;
    assign mac_weight     = weight_q;
    assign mac_acc        = acc_q;
    assign mac_exp_min    = exp_q;
    assign res_acc        = acc_q;
    assign res_exp        = exp_q;
    assign res_count      = count_q;
    assign res_err        = err_q;

endmodule
